// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/LOADIR/DECODE/EXEC/DATA/WB sequencer for the accumulator CPU,
// with memory wait-state timeout, skip-if-zero, halt/resume and a sticky trap state.
module multicycle_ctrl_fsm #(
    parameter int OPCODE_W = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                run,
    output logic                pc_load,
    output logic                pc_en,
    output logic                ir_load,
    output logic                addr_sel,
    output logic                mem_en,
    output logic                mem_we,
    output logic                alu_en,
    output logic                acc_load,
    output logic                acc_src,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state_o
);

    localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LOADIR = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DATA   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          cause_q, cause_d;
    logic [2:0]          op_lo;
    logic                illegal_op;
    logic                timeout;
    logic                is_sto;

    assign op_lo  = op_q[2:0];
    assign is_sto = (op_lo == 3'b110);

    generate
        if (OPCODE_W > 3) begin : g_wide_op
            assign illegal_op = |op_q[OPCODE_W-1:3];
        end else begin : g_narrow_op
            assign illegal_op = 1'b0;
        end
    endgenerate

    // The cycle that would be the WAIT_MAX-th consecutive stall traps unless memory answers.
    assign timeout = (WAIT_MAX > 0) && !mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = '0;
        cause_d    = cause_q;
        pc_load    = 1'b0;
        pc_en      = 1'b0;
        ir_load    = 1'b0;
        addr_sel   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        alu_en     = 1'b0;
        acc_load   = 1'b0;
        acc_src    = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;
        trap_cause = cause_q;
        state_o    = state_q;

        case (state_q)
            S_FETCH: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    state_d = S_LOADIR;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOADIR: begin
                ir_load = 1'b1;
                pc_en   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (illegal_op) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    case (op_lo)
                        3'b000: state_d = S_HALT;
                        3'b001: begin
                            pc_en   = zero;
                            state_d = S_FETCH;
                        end
                        3'b111: begin
                            pc_load = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_DATA;
                    endcase
                end
            end
            S_DATA: begin
                mem_en   = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sto;
                if (mem_ready) begin
                    state_d = is_sto ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                acc_load = 1'b1;
                alu_en   = (op_lo == 3'b010) || (op_lo == 3'b011) || (op_lo == 3'b100);
                acc_src  = (op_lo == 3'b101);
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset blanks every output in the same cycle so no partial write reaches memory.
        if (rst) begin
            pc_load    = 1'b0;
            pc_en      = 1'b0;
            ir_load    = 1'b0;
            addr_sel   = 1'b0;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            alu_en     = 1'b0;
            acc_load   = 1'b0;
            acc_src    = 1'b0;
            halted     = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'b00;
            state_o    = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Instruction-level bench: each instruction is expanded into its expected per-cycle
// output trace, then replayed in lockstep against the sequencer.
module tb_multicycle_ctrl_fsm;

    localparam int TB_WAIT_MAX = 4;

    localparam logic [10:0] F_PCL  = 11'h400;
    localparam logic [10:0] F_PCEN = 11'h200;
    localparam logic [10:0] F_IRL  = 11'h100;
    localparam logic [10:0] F_ASEL = 11'h080;
    localparam logic [10:0] F_MEM  = 11'h040;
    localparam logic [10:0] F_WE   = 11'h020;
    localparam logic [10:0] F_ALU  = 11'h010;
    localparam logic [10:0] F_ACC  = 11'h008;
    localparam logic [10:0] F_SRC  = 11'h004;
    localparam logic [10:0] F_HLT  = 11'h002;
    localparam logic [10:0] F_TRP  = 11'h001;

    typedef struct {
        logic [15:0] exp;
        bit          rst;
        bit          rdy;
        bit          rn;
        logic [3:0]  opc;
        bit          z;
    } cyc_t;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       run;
    logic       pc_load, pc_en, ir_load, addr_sel, mem_en, mem_we;
    logic       alu_en, acc_load, acc_src, halted, trap;
    logic [1:0] trap_cause;
    logic [2:0] state_o;
    logic [15:0] dut_vec;

    cyc_t bld[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    multicycle_ctrl_fsm #(
        .OPCODE_W(4),
        .WAIT_MAX(TB_WAIT_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .run       (run),
        .pc_load   (pc_load),
        .pc_en     (pc_en),
        .ir_load   (ir_load),
        .addr_sel  (addr_sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .alu_en    (alu_en),
        .acc_load  (acc_load),
        .acc_src   (acc_src),
        .halted    (halted),
        .trap      (trap),
        .trap_cause(trap_cause),
        .state_o   (state_o)
    );

    assign dut_vec = {state_o, trap_cause, pc_load, pc_en, ir_load, addr_sel, mem_en,
                      mem_we, alu_en, acc_load, acc_src, halted, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit r();
        return bit'($urandom % 2);
    endfunction

    function automatic logic [3:0] ro();
        return 4'($urandom % 16);
    endfunction

    function automatic void add(input int st, input logic [10:0] fl, input bit rdy, input bit rn,
                                input logic [3:0] opc, input bit z, input logic [1:0] cause);
        cyc_t c;
        c.exp = {3'(st), cause, fl};
        c.rst = 1'b0;
        c.rdy = rdy;
        c.rn  = rn;
        c.opc = opc;
        c.z   = z;
        bld.push_back(c);
    endfunction

    function automatic void add_rst();
        cyc_t c;
        c.exp = 16'h0000;
        c.rst = 1'b1;
        c.rdy = r();
        c.rn  = r();
        c.opc = ro();
        c.z   = r();
        bld.push_back(c);
    endfunction

    // A trapped machine sits in TRAP for a few cycles, then the bench resets it.
    function automatic void trap_tail(input logic [1:0] cause);
        for (int i = 0; i < 3; i++) add(7, F_TRP, r(), r(), ro(), r(), cause);
        add_rst();
    endfunction

    // w stall cycles then ready; returns 0 if the stalls ran into the timeout.
    function automatic bit wait_phase(input int st, input logic [10:0] fl, input int w);
        for (int i = 0; i <= w; i++) begin
            if (i == w) begin
                add(st, fl, 1'b1, r(), ro(), r(), 2'b00);
                return 1'b1;
            end
            add(st, fl, 1'b0, r(), ro(), r(), 2'b00);
            if (i == TB_WAIT_MAX - 1) begin
                trap_tail(2'b10);
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic void gen(input int opc, input int wf, input int wd, input int h,
                                input bit zx, input int abort_at);
        bit sto;
        bld.delete();
        if (wait_phase(0, F_MEM, wf)) begin
            add(1, F_IRL | F_PCEN, r(), r(), ro(), r(), 2'b00);
            add(2, 11'h0, r(), r(), 4'(opc), r(), 2'b00);
            if (opc >= 8) begin
                add(3, 11'h0, r(), r(), ro(), r(), 2'b00);
                trap_tail(2'b01);
            end else if (opc == 0) begin
                add(3, 11'h0, r(), r(), ro(), r(), 2'b00);
                for (int i = 0; i < h; i++) add(6, F_HLT, r(), 1'b0, ro(), r(), 2'b00);
                add(6, F_HLT, r(), 1'b1, ro(), r(), 2'b00);
            end else if (opc == 1) begin
                add(3, zx ? F_PCEN : 11'h0, r(), r(), ro(), zx, 2'b00);
            end else if (opc == 7) begin
                add(3, F_PCL, r(), r(), ro(), r(), 2'b00);
            end else begin
                add(3, 11'h0, r(), r(), ro(), r(), 2'b00);
                sto = (opc == 6);
                if (wait_phase(4, F_MEM | F_ASEL | (sto ? F_WE : 11'h0), wd) && !sto)
                    add(5, F_ACC | ((opc <= 4) ? F_ALU : 11'h0) | ((opc == 5) ? F_SRC : 11'h0),
                        r(), r(), ro(), r(), 2'b00);
            end
        end
        if (abort_at >= 0 && abort_at < bld.size()) begin
            while (bld.size() > abort_at) void'(bld.pop_back());
            add_rst();
        end
    endfunction

    function automatic int cnt_flag(input logic [10:0] f);
        int n = 0;
        foreach (bld[i]) if ((bld[i].exp[10:0] & f) != 11'h0) n++;
        return n;
    endfunction

    task automatic pin(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic play(input string tag);
        for (int i = 0; i < bld.size(); i++) begin
            @(negedge clk);
            rst       = bld[i].rst;
            mem_ready = bld[i].rdy;
            run       = bld[i].rn;
            opcode    = bld[i].opc;
            zero      = bld[i].z;
            #1;
            n_cmp++;
            if (dut_vec !== bld[i].exp) begin
                n_bad++;
                $display("FAIL %s cyc %0d: {state,cause,flags} got %h expected %h",
                         tag, i, dut_vec, bld[i].exp);
            end
        end
    endtask

    initial begin
        int opc, wf, wd, ab;
        rst = 1'b1;
        opcode = 4'h0;
        zero = 1'b0;
        mem_ready = 1'b0;
        run = 1'b0;

        bld.delete();
        for (int i = 0; i < 3; i++) add_rst();
        play("reset");

        gen(2, 0, 0, 0, 1'b0, -1);
        pin("lat_add", bld.size(), 6);
        pin("add_acc_load", cnt_flag(F_ACC), 1);
        play("T1_add");
        gen(5, 0, 0, 0, 1'b0, -1);
        pin("lda_src", cnt_flag(F_SRC), 1);
        play("lda");

        gen(6, 0, 3, 0, 1'b0, -1);
        pin("sto_we_cycles", cnt_flag(F_WE), 4);
        pin("sto_no_acc", cnt_flag(F_ACC), 0);
        play("T2_sto_wait");
        gen(6, 0, 0, 0, 1'b0, -1);
        pin("lat_sto", bld.size(), 5);
        play("sto");

        gen(1, 0, 0, 0, 1'b1, -1);
        pin("skz_z1_pcen", cnt_flag(F_PCEN), 2);
        play("T3_skz_z1");
        gen(1, 0, 0, 0, 1'b0, -1);
        pin("skz_z0_pcen", cnt_flag(F_PCEN), 1);
        pin("lat_skz", bld.size(), 4);
        play("T3_skz_z0");

        gen(0, 0, 0, 10, 1'b0, -1);
        pin("hlt_cycles", cnt_flag(F_HLT), 11);
        play("T4_hlt");
        gen(7, 0, 0, 0, 1'b0, -1);
        pin("jmp_pcl", cnt_flag(F_PCL), 1);
        pin("lat_jmp", bld.size(), 4);
        play("T4_jmp");

        gen(2, 4, 0, 0, 1'b0, -1);
        pin("timeout_fetch_cycles", bld.size(), 8);
        play("T5_fetch_timeout");
        gen(2, 3, 0, 0, 1'b0, -1);
        play("T5_ready_last");
        gen(3, 0, 5, 0, 1'b0, -1);
        play("data_timeout");

        gen(9, 0, 0, 0, 1'b0, -1);
        play("T6_illegal");
        gen(6, 0, 2, 0, 1'b0, 5);
        pin("abort_we_cycles", cnt_flag(F_WE), 1);
        play("T6_rst_mid_data");
        gen(4, 1, 1, 0, 1'b0, -1);
        play("after_abort");

        for (int n = 0; n < 400; n++) begin
            opc = ($urandom % 10 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            wf  = ($urandom % 5 == 0) ? int'($urandom_range(1, 5)) : 0;
            wd  = ($urandom % 5 == 0) ? int'($urandom_range(1, 5)) : 0;
            ab  = ($urandom % 12 == 0) ? int'($urandom_range(0, 8)) : -1;
            gen(opc, wf, wd, int'($urandom_range(0, 4)), r(), ab);
            play("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
